// File: rtl/vga_pkg.sv
// Shared types and timing constants for the VGA colour path.
// H_ACTIVE/V_ACTIVE are also used by the timing controller.
package vga_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      UP    = 2'd0,
      DOWN  = 2'd1,
      LEFT  = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } cmd_state_t;

   // Move pos by step towards zero (neg=1) or up to limit (neg=0).
   // The arithmetic saturates at both ends instead of wrapping.
   function automatic logic [9:0] step_clamp(input logic [9:0] pos,
                                             input logic neg,
                                             input logic [10:0] step,
                                             input logic [10:0] limit);
      logic [10:0] wide;
      wide = {1'b0, pos};
      if (neg) begin
         return (wide < step) ? 10'd0 : 10'(wide - step);
      end
      return ((wide + step) > limit) ? limit[9:0] : 10'(wide + step);
   endfunction

endpackage

// File: rtl/sprite_pos_ctrl.sv
// Sprite position controller: accepts direction commands into a shadow
// position and publishes it as the active position at the next frame start.
module sprite_pos_ctrl #(
   parameter int H_ACTIVE    = vga_pkg::H_ACTIVE,
   parameter int V_ACTIVE    = vga_pkg::V_ACTIVE,
   parameter int SPRITE_SIZE = 32,
   parameter int STEP        = 32
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pix_en,
   input  logic       frame_start,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_dir,
   output logic       cmd_ready,
   output logic [9:0] sx,
   output logic [9:0] sy
);
   import vga_pkg::*;

   localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - SPRITE_SIZE);
   localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - SPRITE_SIZE);
   localparam logic [10:0] STEP_W = 11'(STEP);

   cmd_state_t state;
   cmd_state_t state_next;
   dir_t       dir;
   logic       accept;
   logic       commit;
   logic [9:0] shadow_x;
   logic [9:0] shadow_y;
   logic [9:0] shadow_x_next;
   logic [9:0] shadow_y_next;

   assign dir = dir_t'(cmd_dir);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
      end else begin
         state     <= state_next;
         cmd_ready <= (state_next == IDLE);
      end
   end

   // Only one move may be in flight; a command seen on the commit cycle is ignored.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      commit     = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid) begin
               accept     = 1'b1;
               state_next = PENDING;
            end
         end
         PENDING: begin
            if (pix_en && frame_start) begin
               commit     = 1'b1;
               state_next = IDLE;
            end
         end
      endcase
   end

   // In IDLE the shadow always equals the active position, so it is the base.
   always_comb begin
      shadow_x_next = shadow_x;
      shadow_y_next = shadow_y;
      case (dir)
         UP:    shadow_y_next = step_clamp(shadow_y, 1'b1, STEP_W, Y_MAX);
         DOWN:  shadow_y_next = step_clamp(shadow_y, 1'b0, STEP_W, Y_MAX);
         LEFT:  shadow_x_next = step_clamp(shadow_x, 1'b1, STEP_W, X_MAX);
         RIGHT: shadow_x_next = step_clamp(shadow_x, 1'b0, STEP_W, X_MAX);
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_x <= '0;
         shadow_y <= '0;
         sx       <= '0;
         sy       <= '0;
      end else begin
         if (accept) begin
            shadow_x <= shadow_x_next;
            shadow_y <= shadow_y_next;
         end
         if (commit) begin
            sx <= shadow_x;
            sy <= shadow_y;
         end
      end
   end

endmodule

// File: rtl/vga_sprite_painter.sv
// Two-stage pixel colour pipeline: grid background plus one movable sprite,
// with sync/blank delayed alongside so colour stays aligned to timing.
module vga_sprite_painter #(
   parameter int          H_ACTIVE     = vga_pkg::H_ACTIVE,
   parameter int          V_ACTIVE     = vga_pkg::V_ACTIVE,
   parameter int          CELL_LOG2    = 5,
   parameter int          SPRITE_SIZE  = 32,
   parameter int          STEP         = 32,
   parameter logic [23:0] BG_COLOR     = 24'h102040,
   parameter logic [23:0] GRID_COLOR   = 24'h808080,
   parameter logic [23:0] SPRITE_COLOR = 24'hFF2000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       pix_en,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       blank_in,
   input  logic       hsync_in,
   input  logic       vsync_in,
   input  logic       frame_start,
   input  logic       cmd_valid,
   input  logic [1:0] cmd_dir,
   output logic       cmd_ready,
   output logic [7:0] r,
   output logic [7:0] g,
   output logic [7:0] b,
   output logic       hsync,
   output logic       vsync,
   output logic       blank
);
   import vga_pkg::*;

   localparam logic [10:0] SIZE_W = 11'(SPRITE_SIZE);

   logic [9:0]  sx;
   logic [9:0]  sy;
   logic [10:0] x_w;
   logic [10:0] y_w;
   logic [10:0] sx_w;
   logic [10:0] sy_w;
   logic        hit_sprite;
   logic        hit_grid;
   logic        hit_sprite_q;
   logic        hit_grid_q;
   logic        blank_q;
   logic        hsync_q;
   logic        vsync_q;
   rgb_t        pixel;

   sprite_pos_ctrl #(
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .SPRITE_SIZE (SPRITE_SIZE),
      .STEP        (STEP)
   ) u_pos (
      .clock       (clock),
      .reset       (reset),
      .pix_en      (pix_en),
      .frame_start (frame_start),
      .cmd_valid   (cmd_valid),
      .cmd_dir     (cmd_dir),
      .cmd_ready   (cmd_ready),
      .sx          (sx),
      .sy          (sy)
   );

   // 11-bit compares so sx+SPRITE_SIZE cannot wrap near the right/bottom edge.
   assign x_w  = {1'b0, x};
   assign y_w  = {1'b0, y};
   assign sx_w = {1'b0, sx};
   assign sy_w = {1'b0, sy};

   assign hit_sprite = (x_w >= sx_w) && (x_w < (sx_w + SIZE_W)) &&
                       (y_w >= sy_w) && (y_w < (sy_w + SIZE_W));
   assign hit_grid   = (x[CELL_LOG2-1:0] == '0) || (y[CELL_LOG2-1:0] == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hit_sprite_q <= 1'b0;
         hit_grid_q   <= 1'b0;
         blank_q      <= 1'b0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
      end else if (pix_en) begin
         hit_sprite_q <= hit_sprite;
         hit_grid_q   <= hit_grid;
         blank_q      <= blank_in;
         hsync_q      <= hsync_in;
         vsync_q      <= vsync_in;
      end
   end

   always_comb begin
      pixel = '0;
      if (blank_q) begin
         if (hit_sprite_q) begin
            pixel = rgb_t'(SPRITE_COLOR);
         end else if (hit_grid_q) begin
            pixel = rgb_t'(GRID_COLOR);
         end else begin
            pixel = rgb_t'(BG_COLOR);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r     <= '0;
         g     <= '0;
         b     <= '0;
         hsync <= 1'b0;
         vsync <= 1'b0;
         blank <= 1'b0;
      end else if (pix_en) begin
         r     <= pixel.r;
         g     <= pixel.g;
         b     <= pixel.b;
         hsync <= hsync_q;
         vsync <= vsync_q;
         blank <= blank_q;
      end
   end

endmodule

// File: tb/tb_vga_sprite_painter.sv
// Randomised bench for vga_sprite_painter: a pixel/position model predicts
// RGB, delayed syncs and cmd_ready; all comparisons go through checkOutput.
module tb_vga_sprite_painter;

   localparam logic [23:0] BG_C   = 24'h102040;
   localparam logic [23:0] GRID_C = 24'h808080;
   localparam logic [23:0] SPR_C  = 24'hFF2000;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       pix_en = 1'b0;
   logic [9:0] x = '0;
   logic [9:0] y = '0;
   logic       blank_in = 1'b0;
   logic       hsync_in = 1'b0;
   logic       vsync_in = 1'b0;
   logic       frame_start = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [1:0] cmd_dir = '0;
   logic       cmd_ready;
   logic [7:0] r;
   logic [7:0] g;
   logic [7:0] b;
   logic       hsync;
   logic       vsync;
   logic       blank;

   int tests_run = 0;
   int tests_failed = 0;

   // Model: active sprite position, the move waiting for a frame start, and
   // expected outputs {blank, hsync, vsync, rgb} in strobe order.
   int          m_sx, m_sy, m_shx, m_shy;
   bit          m_pending;
   logic [26:0] exp_q[$];

   always #5 clock = ~clock;

   vga_sprite_painter dut (
      .clock       (clock),
      .reset       (reset),
      .pix_en      (pix_en),
      .x           (x),
      .y           (y),
      .blank_in    (blank_in),
      .hsync_in    (hsync_in),
      .vsync_in    (vsync_in),
      .frame_start (frame_start),
      .cmd_valid   (cmd_valid),
      .cmd_dir     (cmd_dir),
      .cmd_ready   (cmd_ready),
      .r           (r),
      .g           (g),
      .b           (b),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank)
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   function automatic logic [23:0] exp_rgb(input int px, input int py, input bit bl);
      if (!bl) return 24'h0;
      if (px >= m_sx && px < m_sx + 32 && py >= m_sy && py < m_sy + 32) return SPR_C;
      if (px % 32 == 0 || py % 32 == 0) return GRID_C;
      return BG_C;
   endfunction

   function automatic int clip(input int v, input int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic model_cmd(input int dir);
      int nx, ny;
      nx = m_sx;
      ny = m_sy;
      case (dir)
         0: ny = m_sy - 32;
         1: ny = m_sy + 32;
         2: nx = m_sx - 32;
         default: nx = m_sx + 32;
      endcase
      m_shx = clip(nx, 640 - 32);
      m_shy = clip(ny, 480 - 32);
      m_pending = 1'b1;
   endtask

   // One clock cycle: drive inputs, advance the model, compare after the edge.
   task automatic applyStimulus(input bit pe, input int px, input int py, input bit fs,
                                input bit cv, input int cd);
      bit          bl, hs, vs;
      logic [26:0] item;
      bl = (px < 640) && (py < 480);
      hs = 1'($urandom_range(0, 1));
      vs = 1'($urandom_range(0, 1));
      pix_en      = pe;
      x           = 10'(px);
      y           = 10'(py);
      blank_in    = bl;
      hsync_in    = hs;
      vsync_in    = vs;
      frame_start = fs;
      cmd_valid   = cv;
      cmd_dir     = 2'(cd);
      if (pe) exp_q.push_back({bl, hs, vs, exp_rgb(px, py, bl)});
      @(posedge clock);
      #1;
      if (cv && !m_pending) begin
         model_cmd(cd);
      end else if (m_pending && pe && fs) begin
         m_sx = m_shx;
         m_sy = m_shy;
         m_pending = 1'b0;
      end
      if (pe) begin
         item = exp_q.pop_front();
         checkOutput("rgb", {8'h0, r, g, b}, {8'h0, item[23:0]});
         checkOutput("blank", blank, item[26]);
         checkOutput("hsync", hsync, item[25]);
         checkOutput("vsync", vsync, item[24]);
      end
      checkOutput("cmd_ready", cmd_ready, !m_pending);
      pix_en      = 1'b0;
      frame_start = 1'b0;
      cmd_valid   = 1'b0;
   endtask

   // pix_en on every second cycle; the optional command rides the idle cycle.
   task automatic pixel(input int px, input int py, input bit fs, input bit cv, input int cd);
      applyStimulus(1'b0, px, py, 1'b0, cv, cd);
      applyStimulus(1'b1, px, py, fs, 1'b0, cd);
   endtask

   task automatic run_frame(input bit do_cmd, input int dir, input int n_rand);
      int bx, by;
      pixel(0, 0, 1'b1, 1'b0, 0);
      bx = m_sx;
      by = m_sy;
      pixel(bx, by, 1'b0, 1'b0, 0);
      pixel(bx + 31, by + 31, 1'b0, 1'b0, 0);
      pixel(bx + 32, by, 1'b0, 1'b0, 0);
      pixel(bx, by + 32, 1'b0, 1'b0, 0);
      if (bx > 0) pixel(bx - 1, by, 1'b0, 1'b0, 0);
      if (by > 0) pixel(bx, by - 1, 1'b0, 1'b0, 0);
      if (do_cmd) pixel(bx + 5, by + 5, 1'b0, 1'b1, dir);
      pixel(bx + 31, by, 1'b0, 1'b0, 0);
      pixel(bx + 32, by + 1, 1'b0, 1'b0, 0);
      pixel(5, 5, 1'b0, 1'b0, 0);
      pixel(0, 7, 1'b0, 1'b0, 0);
      pixel(31, 31, 1'b0, 1'b0, 0);
      pixel(639, 0, 1'b0, 1'b0, 0);
      pixel(608, 0, 1'b0, 1'b0, 0);
      pixel(607, 0, 1'b0, 1'b0, 0);
      pixel(700, 10, 1'b0, 1'b0, 0);
      for (int i = 0; i < n_rand; i++) begin
         pixel($urandom_range(0, 799), $urandom_range(0, 524), 1'b0,
               ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
      end
   endtask

   // Asynchronous assert: outputs must clear before any clock edge arrives.
   task automatic do_reset();
      pix_en    = 1'b0;
      cmd_valid = 1'b0;
      reset     = 1'b1;
      #1;
      checkOutput("rst_rgb", {8'h0, r, g, b}, 32'h0);
      checkOutput("rst_sync", {hsync, vsync, blank}, 3'b000);
      checkOutput("rst_ready", cmd_ready, 1'b1);
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      m_sx = 0;
      m_sy = 0;
      m_shx = 0;
      m_shy = 0;
      m_pending = 1'b0;
      exp_q.delete();
      exp_q.push_back(27'h0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      #2;
      do_reset();

      // Plain scan, then a right move issued mid-frame and visible one frame later
      run_frame(1'b0, 0, 8);
      run_frame(1'b1, 3, 8);
      run_frame(1'b0, 0, 6);

      // Up and left at the origin clamp but still occupy a frame each
      do_reset();
      run_frame(1'b1, 0, 4);
      run_frame(1'b1, 2, 4);
      run_frame(1'b0, 0, 4);

      // Twenty right moves saturate at x = 608
      do_reset();
      for (int i = 0; i < 20; i++) run_frame(1'b1, 3, 2);
      run_frame(1'b0, 0, 4);

      // A command presented on the committing frame_start strobe is dropped
      run_frame(1'b1, 1, 2);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0);
      applyStimulus(1'b1, 0, 0, 1'b1, 1'b1, 1);
      pixel(m_sx + 1, m_sy + 1, 1'b0, 1'b0, 0);
      run_frame(1'b0, 0, 2);

      // Reset while a move is pending discards it and homes the sprite
      run_frame(1'b1, 1, 2);
      pixel(m_sx + 1, m_sy + 1, 1'b0, 1'b0, 0);
      pixel(m_sx + 2, m_sy + 2, 1'b0, 1'b0, 0);
      do_reset();
      run_frame(1'b0, 0, 4);

      for (int f = 0; f < 25; f++) begin
         run_frame(1'($urandom_range(0, 1)), $urandom_range(0, 3), 6);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
